// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
//   Definitions shared by ALU_Control and the iterative_alu execution stage:
//   the 4-bit ALU operation codes, the execution FSM state type and a helper
//   that identifies the operations executed by the iterative shifter.
// -----------------------------------------------------------------------------
package alu_pkg;

  // ALU operation codes produced by ALU_Control.
  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_AND = 4'b0010;
  localparam logic [3:0] ALU_OR  = 4'b0011;
  localparam logic [3:0] ALU_XOR = 4'b0100;
  localparam logic [3:0] ALU_SLL = 4'b0110;
  localparam logic [3:0] ALU_SRL = 4'b0111;
  localparam logic [3:0] ALU_SRA = 4'b1000;
  localparam logic [3:0] ALU_LUI = 4'b1001;

  // Execution FSM: IDLE accepts requests, SHIFT iterates one bit per clock.
  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } alu_state_t;

  // True for the operations that go through the one-bit-per-clock shifter.
  function automatic logic is_shift_op(input logic [3:0] op);
    return (op == ALU_SLL) || (op == ALU_SRL) || (op == ALU_SRA);
  endfunction

endpackage : alu_pkg

// File: rtl/iterative_alu_shift_step.sv
// -----------------------------------------------------------------------------
// shift_step
//   Combinational single-bit shift of the iterative shifter accumulator.
//   One instance is reused every clock while the ALU sits in SHIFT, which is
//   what replaces a full barrel shifter.
//
// Ports:
//   i_op   in   4           shift kind (ALU_SLL / ALU_SRL / ALU_SRA)
//   i_acc  in   DATA_WIDTH  current accumulator value
//   o_acc  out  DATA_WIDTH  accumulator shifted by one position
//                           (passes i_acc through for any other code)
// -----------------------------------------------------------------------------
module shift_step
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [3:0]            i_op,
  input  logic [DATA_WIDTH-1:0] i_acc,
  output logic [DATA_WIDTH-1:0] o_acc
);

  // NOTE: o_acc gets a default before the case so every path assigns it;
  // without it an unlisted op code would infer a latch.
  always_comb begin
    o_acc = i_acc;
    case (i_op)
      ALU_SLL: o_acc = {i_acc[DATA_WIDTH-2:0], 1'b0};            // zero into LSB
      ALU_SRL: o_acc = {1'b0, i_acc[DATA_WIDTH-1:1]};            // zero into MSB
      ALU_SRA: o_acc = {i_acc[DATA_WIDTH-1], i_acc[DATA_WIDTH-1:1]}; // sign fill
      default: o_acc = i_acc;
    endcase
  end

endmodule : shift_step

// File: rtl/iterative_alu.sv
// -----------------------------------------------------------------------------
// iterative_alu
//   Execution stage downstream of ALU_Control. Single-cycle for arithmetic,
//   logic, lui and unknown codes; shifts run one bit per clock so the datapath
//   can stall the PC on busy_o until done_o.
//
// Ports:
//   clk              in   1           system clock, rising edge
//   reset            in   1           asynchronous, active-low reset
//   start_i          in   1           request, sampled only while busy_o = 0
//   ALU_Operation_i  in   4           op code from ALU_Control
//   A_i              in   DATA_WIDTH  operand A (rs1)
//   B_i              in   DATA_WIDTH  operand B (rs2/imm); low SHAMT_WIDTH
//                                     bits are the shift amount
//   ALU_Result_o     out  DATA_WIDTH  registered result, held until next done
//   Zero_o           out  1           registered (ALU_Result_o == 0)
//   busy_o           out  1           high while a shift is iterating
//   done_o           out  1           one-cycle pulse when result/zero update
// -----------------------------------------------------------------------------
module iterative_alu
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int SHAMT_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start_i,
  input  logic [3:0]            ALU_Operation_i,
  input  logic [DATA_WIDTH-1:0] A_i,
  input  logic [DATA_WIDTH-1:0] B_i,
  output logic [DATA_WIDTH-1:0] ALU_Result_o,
  output logic                  Zero_o,
  output logic                  busy_o,
  output logic                  done_o
);

  localparam logic [SHAMT_WIDTH-1:0] CNT_ONE = SHAMT_WIDTH'(1);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  alu_state_t             r_state;
  logic [3:0]             r_op;      // shift kind latched at accept
  logic [DATA_WIDTH-1:0]  r_acc;     // partially shifted operand
  logic [SHAMT_WIDTH-1:0] r_cnt;     // shift steps still to perform
  logic [DATA_WIDTH-1:0]  r_result;
  logic                   r_zero;
  logic                   r_done;

  alu_state_t             w_state_nxt;
  logic [3:0]             w_op_nxt;
  logic [DATA_WIDTH-1:0]  w_acc_nxt;
  logic [SHAMT_WIDTH-1:0] w_cnt_nxt;
  logic [DATA_WIDTH-1:0]  w_result_nxt;
  logic                   w_zero_nxt;
  logic                   w_done_nxt;

  logic [SHAMT_WIDTH-1:0] w_shamt;
  logic [DATA_WIDTH-1:0]  w_single;
  logic [DATA_WIDTH-1:0]  w_step_acc;

  assign w_shamt = B_i[SHAMT_WIDTH-1:0];

  // ---------------------------------------------------------------------------
  // Single-cycle result. Shift codes land here only with shamt = 0, where the
  // result is A unchanged.
  // ---------------------------------------------------------------------------
  always_comb begin
    w_single = '0;
    case (ALU_Operation_i)
      ALU_ADD: w_single = A_i + B_i;   // carry dropped
      ALU_SUB: w_single = A_i - B_i;   // borrow dropped
      ALU_AND: w_single = A_i & B_i;
      ALU_OR:  w_single = A_i | B_i;
      ALU_XOR: w_single = A_i ^ B_i;
      ALU_SLL,
      ALU_SRL,
      ALU_SRA: w_single = A_i;
      ALU_LUI: w_single = B_i;
      default: w_single = '0;          // unknown codes still complete
    endcase
  end

  // One-bit shift of the accumulator, selected by the latched shift kind.
  shift_step #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_shift_step (
    .i_op  (r_op),
    .i_acc (r_acc),
    .o_acc (w_step_acc)
  );

  // ---------------------------------------------------------------------------
  // Next-state and datapath control
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_nxt  = r_state;
    w_op_nxt     = r_op;
    w_acc_nxt    = r_acc;
    w_cnt_nxt    = r_cnt;
    w_result_nxt = r_result;
    w_done_nxt   = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (start_i) begin
          if (is_shift_op(ALU_Operation_i) && (w_shamt != '0)) begin
            // Operands are captured here; inputs are free after this edge.
            w_state_nxt = ST_SHIFT;
            w_op_nxt    = ALU_Operation_i;
            w_acc_nxt   = A_i;
            w_cnt_nxt   = w_shamt;
          end else begin
            w_result_nxt = w_single;
            w_done_nxt   = 1'b1;
          end
        end
      end

      ST_SHIFT: begin
        // start_i is ignored here; requests are not queued.
        w_acc_nxt = w_step_acc;
        w_cnt_nxt = r_cnt - CNT_ONE;
        if (r_cnt == CNT_ONE) begin
          // Last step: publish the shifted value on this same edge so the
          // total latency equals shamt clocks from the accept edge.
          w_result_nxt = w_step_acc;
          w_done_nxt   = 1'b1;
          w_state_nxt  = ST_IDLE;
        end
      end

      default: w_state_nxt = ST_IDLE;
    endcase

    // Zero flag only moves together with the result.
    w_zero_nxt = w_done_nxt ? (w_result_nxt == '0) : r_zero;
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values computed above, independent of statement order.
  // NOTE: the accumulator and counter are reset too (not just the FSM) so an
  // aborted shift leaves no stale operand behind.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= ST_IDLE;
      r_op     <= ALU_ADD;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_result <= '0;
      r_zero   <= 1'b1;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_op     <= w_op_nxt;
      r_acc    <= w_acc_nxt;
      r_cnt    <= w_cnt_nxt;
      r_result <= w_result_nxt;
      r_zero   <= w_zero_nxt;
      r_done   <= w_done_nxt;
    end
  end

  assign ALU_Result_o = r_result;
  assign Zero_o       = r_zero;
  assign busy_o       = (r_state == ST_SHIFT);
  assign done_o       = r_done;

endmodule : iterative_alu
